// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter. Sends one NB_DATA-bit word
// per handshake as start bit, LSB-first data, optional parity, 1 or 2 stops.
// Bit timing is N_TICKS pulses of the external oversampling tick.
//
// Handshake: a word is accepted on any rising edge where i_valid && o_ready.
// o_ready is a registered output that is high only while idle. i_data is
// sampled only on that accept edge. i_valid while o_ready is low is ignored
// and nothing is queued.
module uart_tx_frame #(
  parameter int NB_DATA = 8,
  parameter int N_TICKS = 16,
  parameter int PARITY  = 0,
  parameter int NB_STOP = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_ready,
  output logic               o_tx_data,
  output logic               o_done,
  output logic [2:0]         o_dbg_state
);

  localparam int TW        = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int BW        = $clog2(NB_DATA + 1);
  // Parity values other than 1 (odd) or 2 (even) fall back to no parity.
  localparam bit HAS_PAR   = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR   = (PARITY == 1);
  // Anything other than 2 stop bits is treated as 1.
  localparam int STOP_BITS = (NB_STOP == 2) ? 2 : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tick_cnt, tick_cnt_next;
  logic [BW-1:0]      bit_cnt, bit_cnt_next;
  logic [NB_DATA-1:0] shreg, shreg_next;
  logic               par, par_next;
  logic               done_next;
  logic               tx_next;
  logic               bit_end;

  assign o_dbg_state = state;

  // Next-state, datapath update and next line value. The line is computed
  // from the next state so the registered output changes on the same edge
  // that moves the FSM.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shreg_next    = shreg;
    par_next      = par;
    done_next     = 1'b0;
    bit_end       = 1'b0;
    tx_next       = 1'b1;

    if (state == S_IDLE) begin
      // Ticks are ignored while idle, including on the accept edge, so the
      // start bit always lasts a full N_TICKS ticks after acceptance.
      if (i_valid && o_ready) begin
        shreg_next    = i_data;
        par_next      = ODD_PAR ? ~^i_data : ^i_data;
        tick_cnt_next = '0;
        state_next    = S_START;
      end
    end else if (i_tick) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt_next = '0;
        bit_end       = 1'b1;
      end else begin
        tick_cnt_next = tick_cnt + 1'b1;
      end
    end

    if (bit_end) begin
      case (state)
        S_START: begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
        end
        S_DATA: begin
          shreg_next = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          state_next   = S_STOP;
          bit_cnt_next = '0;
        end
        S_STOP: begin
          if (bit_cnt == STOP_LAST) begin
            state_next   = S_IDLE;
            bit_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shreg_next[0];
      S_PARITY: tx_next = par_next;
      default:  tx_next = 1'b1;
    endcase
  end

  // State and datapath registers. o_ready is held low for the o_done cycle
  // so that the two are never high together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      o_tx_data <= 1'b1;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      par       <= par_next;
      o_tx_data <= tx_next;
      o_ready   <= (state_next == S_IDLE) && !done_next;
      o_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four configurations of uart_tx_frame driven one at a time.
// The driver pushes the hand-computed serial frame into exp_q before sending;
// the monitor waits for a start bit, pops the entry and checks every bit
// window, the o_done position and the o_ready rise.
module tb_uart_tx_frame;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       tick_1 = 1'b1;
  logic       tick_d = 1'b0;
  int         tick_ph = 0;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic [7:0] data_a, data_b, data_c;
  logic [4:0] data_d;
  logic       ready_a, ready_b, ready_c, ready_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       done_a, done_b, done_c, done_d;
  logic [2:0] dbg_a, dbg_b, dbg_c, dbg_d;
  logic [3:0] tx_v, ready_v, done_v;
  logic       mon_en;
  logic       mon_busy = 1'b0;
  int         last_done_cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign tx_v    = {tx_d, tx_c, tx_b, tx_a};
  assign ready_v = {ready_d, ready_c, ready_b, ready_a};
  assign done_v  = {done_d, done_c, done_b, done_a};

  // 0: 8N1, 16 ticks, tick every cycle
  uart_tx_frame u_a (
    .i_clk(clk), .i_reset(rst), .i_tick(tick_1), .i_valid(valid_a), .i_data(data_a),
    .o_ready(ready_a), .o_tx_data(tx_a), .o_done(done_a), .o_dbg_state(dbg_a));
  // 1: even parity, 2 stop bits, 4 ticks
  uart_tx_frame #(.NB_DATA(8), .N_TICKS(4), .PARITY(2), .NB_STOP(2)) u_b (
    .i_clk(clk), .i_reset(rst), .i_tick(tick_1), .i_valid(valid_b), .i_data(data_b),
    .o_ready(ready_b), .o_tx_data(tx_b), .o_done(done_b), .o_dbg_state(dbg_b));
  // 2: odd parity, 1 stop bit, 4 ticks
  uart_tx_frame #(.NB_DATA(8), .N_TICKS(4), .PARITY(1), .NB_STOP(1)) u_c (
    .i_clk(clk), .i_reset(rst), .i_tick(tick_1), .i_valid(valid_c), .i_data(data_c),
    .o_ready(ready_c), .o_tx_data(tx_c), .o_done(done_c), .o_dbg_state(dbg_c));
  // 3: 5 data bits, 4 ticks, tick every third cycle
  uart_tx_frame #(.NB_DATA(5), .N_TICKS(4), .PARITY(0), .NB_STOP(1)) u_d (
    .i_clk(clk), .i_reset(rst), .i_tick(tick_d), .i_valid(valid_d), .i_data(data_d),
    .o_ready(ready_d), .o_tx_data(tx_d), .o_done(done_d), .o_dbg_state(dbg_d));

  // one-cycle tick every third cycle for instance 3
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
      tick_d  = (tick_ph == 0);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  id;
    logic [3:0]  nbits;
    logic [4:0]  start_len;
    logic [4:0]  bit_len;
    logic [1:0]  gap;
    logic [11:0] bits;     // bit k = k-th serial bit, start bit in bit 0
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int id, input int nb, input int sl, input int bl,
                          input int gap, input logic [11:0] bits);
    exp_t e;
    e.id        = 2'(id);
    e.nbits     = 4'(nb);
    e.start_len = 5'(sl);
    e.bit_len   = 5'(bl);
    e.gap       = 2'(gap);
    e.bits      = bits;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int id, input logic v, input logic [8:0] d);
    case (id)
      0: begin valid_a = v; data_a = d[7:0]; end
      1: begin valid_b = v; data_b = d[7:0]; end
      2: begin valid_c = v; data_c = d[7:0]; end
      default: begin valid_d = v; data_d = d[4:0]; end
    endcase
  endtask

  // returns on a falling edge with o_ready of instance id high
  task automatic wait_ready(input int id);
    int w;
    w = 0;
    @(negedge clk);
    while (ready_v[id] !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout dut=%0d actual=0 required=1", id);
    end
  endtask

  // one-cycle handshake; instance 3 is aligned so a tick lands on the accept edge
  task automatic send(input int id, input logic [8:0] d);
    int w;
    wait_ready(id);
    if (id == 3) begin
      w = 0;
      do begin
        @(posedge clk);
        #2;
        w++;
      end while (!tick_d && w < 10);
    end
    set_in(id, 1'b1, d);
    @(posedge clk);
    #1;
    set_in(id, 1'b0, d);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || mon_busy) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout actual=pending required=empty");
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t        e;
    int          id;
    int          len;
    int          n_done;
    logic [11:0] obs;
    logic        stable;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) continue;
      id = -1;
      for (int i = 0; i < 4; i++) if (id < 0 && tx_v[i] === 1'b0) id = i;
      if (id < 0) continue;
      if (exp_q.size() == 0 || int'(exp_q[0].id) != id) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_start dut=%0d actual=start required=idle", id);
        for (int w = 0; w < 400 && tx_v[id] === 1'b0; w++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      mon_busy = 1'b1;
      if (e.gap != 0) check("start_gap", cyc - last_done_cyc, 32'(e.gap));
      obs    = '0;
      stable = 1'b1;
      n_done = 0;
      for (int k = 0; k < int'(e.nbits); k++) begin
        len = (k == 0) ? int'(e.start_len) : int'(e.bit_len);
        for (int j = 0; j < len; j++) begin
          if (j == 0) obs[k] = tx_v[id];
          else if (tx_v[id] !== obs[k]) stable = 1'b0;
          if (done_v[id] === 1'b1) n_done++;
          @(negedge clk);
        end
      end
      check("frame_bits", 32'(obs), 32'(e.bits));
      check("bit_windows_stable", 32'(stable), 32'd1);
      check("no_early_done", n_done, 0);
      check("end_done_ready_line", {done_v[id], ready_v[id], tx_v[id]}, 32'b101);
      last_done_cyc = cyc;
      @(negedge clk);
      check("ready_after_done", {done_v[id], ready_v[id], tx_v[id]}, 32'b011);
      mon_busy = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int n_low;
    rst    = 1'b1;
    mon_en = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
    data_a = '0; data_b = '0; data_c = '0; data_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_line", 32'(tx_v[i]), 32'd1);
      check("reset_ready", 32'(ready_v[i]), 32'd1);
      check("reset_done", 32'(done_v[i]), 32'd0);
    end
    check("reset_state_a", 32'(dbg_a), 32'd0);
    check("reset_state_d", 32'(dbg_d), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 8N1 0xA5: 0, 1,0,1,0,0,1,0,1, 1
    push_exp(0, 10, 16, 16, 0, 12'h34A);
    send(0, 9'h0A5);
    wait_idle();

    // even parity, 2 stops: 0x07 -> parity 1; 0x03 -> parity 0
    push_exp(1, 12, 4, 4, 0, 12'hE0E);
    send(1, 9'h007);
    wait_idle();
    push_exp(1, 12, 4, 4, 0, 12'hC06);
    send(1, 9'h003);
    wait_idle();

    // odd parity: 0x03 -> parity 1; 0x07 -> parity 0
    push_exp(2, 11, 4, 4, 0, 12'h606);
    send(2, 9'h003);
    wait_idle();
    push_exp(2, 11, 4, 4, 0, 12'h40E);
    send(2, 9'h007);
    wait_idle();

    // 5 data bits, tick every 3rd cycle, tick on the accept edge ignored
    push_exp(3, 7, 12, 12, 0, 12'h07E);
    send(3, 9'h01F);
    wait_idle();
    push_exp(3, 7, 12, 12, 0, 12'h054);
    send(3, 9'h00A);
    wait_idle();

    // back-to-back 0x55 then 0xAA, i_valid held, i_data changed mid-frame
    push_exp(0, 10, 16, 16, 0, 12'h2AA);
    push_exp(0, 10, 16, 16, 2, 12'h354);
    wait_ready(0);
    set_in(0, 1'b1, 9'h055);
    @(posedge clk);
    #1 data_a = 8'h0F;
    repeat (50) @(posedge clk);
    #1 data_a = 8'hAA;
    wait_ready(0);
    @(posedge clk);
    #1 set_in(0, 1'b0, 9'h000);
    wait_idle();

    // reset during data bit 3 of 0xF0 aborts the frame
    mon_en = 1'b0;
    send(0, 9'h0F0);
    repeat (69) @(posedge clk);
    #1;
    check("abort_line_bit3", 32'(tx_a), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_line_high", 32'(tx_a), 32'd1);
    check("abort_ready_high", 32'(ready_a), 32'd1);
    check("abort_done_low", 32'(done_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    n_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_a === 1'b1) n++;
      if (tx_a !== 1'b1) n_low++;
    end
    check("abort_no_done", n, 0);
    check("abort_line_idle", n_low, 0);
    mon_en = 1'b1;
    push_exp(0, 10, 16, 16, 0, 12'h278);
    send(0, 9'h03C);
    wait_idle();

    // i_valid pulsed while busy is ignored
    push_exp(0, 10, 16, 16, 0, 12'h302);
    send(0, 9'h081);
    repeat (30) @(posedge clk);
    #1 set_in(0, 1'b1, 9'h0FF);
    @(posedge clk);
    #1 set_in(0, 1'b0, 9'h000);
    wait_idle();
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_a === 1'b1) n++;
    end
    check("busy_no_extra_done", n, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one NB_DATA-bit word per valid/ready handshake. Frames carry a start bit, LSB-first data, an optional parity bit and one or two stop bits. Bit timing comes from an external oversampling tick (the same baud-rate generator tick the receive path uses), N_TICKS ticks per bit. The block sits between the UART interface logic and the serial pin and replaces the fixed 8N1 transmitter.

## Interface
- NB_DATA, 8: data bits per frame, 5..9.
- N_TICKS, 16: i_tick pulses per bit period, ≥2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- NB_STOP, 1: stop bits, 1 or 2.
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  one-cycle oversampling strobe from the baud generator.
- i_valid  in  1  i_data holds a word to send.
- i_data  in  NB_DATA  word; sampled only on the accept cycle.
- o_ready  out  1  block can accept a word (high only in IDLE).
- o_tx_data  out  1  serial line, registered, idle high.
- o_done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset: i_reset and i_clk as decided above. State IDLE; o_tx_data=1, o_ready=1, o_done=0; tick and bit counters cleared.
- Accept: on an edge with i_valid && o_ready, latch i_data into the shift register. Latch the parity bit: even = ^i_data, odd = ~^i_data. Clear the tick counter and go to START. i_valid with o_ready low is ignored; no queuing.
- States: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- Line value per state: START 0; DATA shift-register LSB; PARITY latched parity bit; STOP 1; IDLE 1.
- Tick counter: width $clog2(N_TICKS), counts i_tick pulses.
  - On a tick with counter = N_TICKS-1 the counter wraps to 0 and the current bit ends.
  - i_tick is ignored in IDLE, including on the accept cycle.
- Bit end, per state:
  - START → DATA.
  - DATA: shift the register right by one and increment the bit counter. After bit NB_DATA-1, go to PARITY, or to STOP when PARITY=0.
  - PARITY → STOP.
  - STOP: increment the bit counter. After NB_STOP stop bits, go to IDLE and assert o_done for that cycle.
- Bit counter: width $clog2(NB_DATA+1). Cleared on entry to DATA and on entry to STOP.
- Frame length: (1 + NB_DATA + (PARITY≠0) + NB_STOP) × N_TICKS ticks.
- Reset mid-frame aborts the frame immediately: line high next cycle, no o_done.
- Illegal PARITY values (3) behave as 0. Illegal NB_STOP values behave as 1.

## Timing
- o_tx_data is registered.
  - Falls to 0 in the cycle after the accept edge.
  - Each later bit change appears in the cycle after the edge that consumed the bit's final tick.
- o_ready falls in the cycle after acceptance. It rises in the cycle after the o_done edge, so o_done and o_ready are never high together.
- Back-to-back: with i_valid held high, the next word is accepted one cycle after the o_done pulse. The line stays 1 for that single cycle, then the next start bit begins.
- Start-bit length is exactly N_TICKS ticks counted after acceptance. Phase relative to the tick stream is not aligned; jitter is up to one tick period.
- No combinational path from inputs to outputs.

## Test plan
- Default 8N1, i_tick every cycle, send 0xA5:
  - Line low 16 cycles, then data 1,0,1,0,0,1,0,1 for 16 cycles each, then 16 cycles high.
  - o_done pulses at cycle 160 after acceptance; o_ready high at cycle 161.
- PARITY=2, NB_STOP=2, send 0x07 → parity bit 1, then 2 stop bits. PARITY=1, send 0x03 → parity bit 1. PARITY=1, send 0x07 → parity bit 0. Frame length 12×N_TICKS ticks.
- NB_DATA=5, N_TICKS=4, i_tick every 3rd cycle, send 0x1F.
  - Each bit lasts 12 cycles; total frame 7 bits = 84 cycles.
  - Verify the tick count per bit, and that ticks in IDLE do not shorten the start bit.
- i_valid held high with 0x55, then 0xAA → second start bit begins exactly 2 cycles after the o_done pulse. Changing i_data mid-frame does not alter the transmitted word.
- Assert i_reset during data bit 3 → o_tx_data=1 and o_ready=1 next cycle, no o_done. A new word then transmits correctly.
- i_valid pulsed while busy → ignored; the frame completes and exactly one o_done is produced.
